shift_add_mult_ctrl: RTL and testbench

Sequential 8x8 unsigned multiplier controller for the RPN ALU.
- Runs shift-and-add over eight iterations through a single shared 8-bit ripple-carry adder instance.
- Accepts operands with a start/ready handshake and returns a 16-bit product with a one-cycle done pulse.
- Sits beside the combinational adders in the ALU execute stage and serves the MUL opcode.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 28 ++
 rtl/shift_add_mult_ctrl_if.sv | 16 +
 rtl/shift_add_mult_ctrl_adder.sv | 25 ++
 rtl/shift_add_mult_ctrl.sv | 92 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 134 +++++++++++++
 5 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the shift-and-add multiplier controller.
package shift_add_mult_ctrl_pkg;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_CNT_W = 3;
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = 3'd7;

  // FSM encodings; 2'b11 is unused and recovers to IDLE.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // Registered result bundle.
  typedef struct packed {
    logic [2*MUL_WIDTH-1:0] p;
    logic                   z;
  } mul_res_t;

  // Builds the result from the upper and lower halves after a shift step.
  function automatic mul_res_t mk_res(input logic [MUL_WIDTH-1:0] hi,
                                      input logic [MUL_WIDTH-1:0] lo);
    mul_res_t r;
    r.p = {hi, lo};
    r.z = (r.p == '0);
    return r;
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake and operand/result bundle for the multiplier.
interface shift_add_mult_ctrl_if;
  import shift_add_mult_ctrl_pkg::*;

  logic                   start;
  logic [MUL_WIDTH-1:0]   A;
  logic [MUL_WIDTH-1:0]   B;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [2*MUL_WIDTH-1:0] P;
  logic                   Z;

  modport master (output start, A, B, input ready, busy, done, P, Z);
  modport slave  (input start, A, B, output ready, busy, done, P, Z);
endinterface

// File: rtl/shift_add_mult_ctrl_adder.sv
// Ripple-carry adder used as the single shared adder of the multiplier.
module A_8bits_fulladder #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] S,
  output logic         Co
);

  logic [W:0] c;

  assign c[0] = Ci;

  // One full-adder cell per bit, carry rippling upward.
  genvar i;
  for (i = 0; i < W; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Co = c[W];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier, fixed 9-cycle latency.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult_ctrl_if.slave bus
);

  // Only the 8-bit shared adder exists, so other widths cannot be built.
  if (WIDTH != MUL_WIDTH || CNT_W != MUL_CNT_W) begin : g_bad_cfg
    $error("shift_add_mult_ctrl: only WIDTH=8, CNT_W=3 supported");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  mul_res_t         res;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Multiplicand is added only when the current multiplier LSB is set.
  assign add_b = q[0] ? m : '0;

  A_8bits_fulladder #(.W(WIDTH)) u_add (
    .A  (acc),
    .B  (add_b),
    .Ci (1'b0),
    .S  (sum),
    .Co (co)
  );

  // Shift the {carry, sum, Q} chain right by one; carry lands in Acc MSB.
  always_comb begin
    acc_nxt = {co, sum[WIDTH-1:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
  end

  // Control FSM, iteration counter and partial-product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      res   <= '{p: '0, z: 1'b1};
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            m     <= bus.A;
            q     <= bus.B;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            res   <= mk_res(acc_nxt, q_nxt);
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status strobes decoded straight from registered state.
  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.busy  = (state == S_RUN);
    bus.done  = (state == S_DONE);
    bus.P     = res.p;
    bus.Z     = res.z;
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench: directed corner cases plus random operands vs A*B.
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] exp_p = 16'h0;

  shift_add_mult_ctrl_if bus ();

  shift_add_mult_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic r, input logic b, input logic d);
    chk({tag, "_ready"}, {31'b0, bus.ready}, {31'b0, r});
    chk({tag, "_busy"},  {31'b0, bus.busy},  {31'b0, b});
    chk({tag, "_done"},  {31'b0, bus.done},  {31'b0, d});
  endtask

  // Full transaction: accept, 8 busy cycles, done in cycle 9, ready in cycle 10.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    logic [15:0] prod;
    while (!bus.ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'b0, bus.ready}, 32'd1);
    prod = 16'(a) * 16'(b);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.A = 8'($urandom); bus.B = 8'($urandom);
      chk_state("run", 1'b0, 1'b1, 1'b0);
      chk("p_hold", {16'b0, bus.P}, {16'b0, exp_p});
      tick();
    end
    exp_p = prod;
    chk_state("c9", 1'b0, 1'b0, 1'b1);
    chk("p", {16'b0, bus.P}, {16'b0, prod});
    chk("z", {31'b0, bus.Z}, {31'b0, prod == 16'h0});
    tick();
    chk_state("c10", 1'b1, 1'b0, 1'b0);
    chk("p_after", {16'b0, bus.P}, {16'b0, prod});
  endtask

  initial begin
    logic saw_done;
    logic [7:0] dir_a [6] = '{8'd13, 8'd255, 8'd128, 8'd0,   8'd200, 8'd1};
    logic [7:0] dir_b [6] = '{8'd11, 8'd255, 8'd2,   8'd200, 8'd0,   8'd1};

    bus.start = 1'b0; bus.A = 8'h0; bus.B = 8'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_state("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_p", {16'b0, bus.P}, 32'h0);
    chk("reset_z", {31'b0, bus.Z}, 32'd1);

    // Directed products: basic, carry-out paths, zero results.
    for (int i = 0; i < 6; i++) do_mul(dir_a[i], dir_b[i]);

    // start held high through RUN and DONE: ignored until ready returns.
    bus.A = 8'd3; bus.B = 8'd5; bus.start = 1'b1;
    tick();
    bus.A = 8'd9; bus.B = 8'd9;
    for (int c = 1; c <= 8; c++) tick();
    chk_state("held_c9", 1'b0, 1'b0, 1'b1);
    chk("held_p1", {16'b0, bus.P}, 32'h000F);
    tick();
    chk("held_c10_ready", {31'b0, bus.ready}, 32'd1);
    tick();
    bus.start = 1'b0;
    chk("held_c11_busy", {31'b0, bus.busy}, 32'd1);
    chk("held_c11_p", {16'b0, bus.P}, 32'h000F);
    for (int c = 12; c <= 19; c++) tick();
    chk("held_c19_done", {31'b0, bus.done}, 32'd1);
    chk("held_p2", {16'b0, bus.P}, 32'h0051);
    tick();
    exp_p = 16'h0051;

    // Reset in the middle of RUN discards the partial product.
    bus.A = 8'd7; bus.B = 8'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_p = 16'h0;
    chk_state("midrst", 1'b1, 1'b0, 1'b0);
    chk("midrst_p", {16'b0, bus.P}, 32'h0);
    chk("midrst_z", {31'b0, bus.Z}, 32'd1);
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    chk("midrst_no_done", {31'b0, saw_done}, 32'd0);
    do_mul(8'd2, 8'd3);

    // Random operands against plain multiplication.
    for (int i = 0; i < 24; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      do_mul(8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
